// File: rtl/regfile_banked_sb_pkg.sv
// Shared types and helpers for the banked-SP register file.
// Latency: n/a (types/functions only). Backpressure: n/a.
package bexkat1_rf_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        BYTE = 2'b01,
        HALF = 2'b10,
        WORD = 2'b11
    } size_t;

    // Extension is done at this fixed width; callers truncate to their WIDTH (16..64).
    localparam int EXT_W = 64;

    localparam int COUNTP_DEF = 4;

    // The ssp sits just past the architectural registers in the flat physical array.
    function automatic int phys_ssp(input int countp);
        return 1 << countp;
    endfunction

    localparam int PHYS_SSP = 1 << COUNTP_DEF;

    function automatic logic [EXT_W-1:0] extend(input size_t sz, input logic sext,
                                                input logic [EXT_W-1:0] data);
        logic [EXT_W-1:0] r;
        case (sz)
            BYTE:    r = {{(EXT_W-8){sext & data[7]}}, data[7:0]};
            HALF:    r = {{(EXT_W-16){sext & data[15]}}, data[15:0]};
            WORD:    r = data;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regfile_banked_sb_if.sv
// Decode/writeback-facing bundle of the banked-SP register file.
// Latency: n/a (wires only). Backpressure: none, all signals are unconditional.
interface regfile_banked_sb_if #(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int NREAD  = 3
);
    logic                    supervisor;
    logic [NREAD*COUNTP-1:0] rd_addr_i;
    logic [NREAD*WIDTH-1:0]  rd_data_o;
    logic [NREAD-1:0]        rd_busy_o;
    logic [COUNTP-1:0]       wr_addr_i;
    logic [WIDTH-1:0]        wr_data_i;
    logic [1:0]              wr_en_i;
    logic                    wr_sext_i;
    logic [WIDTH-1:0]        sp_data_i;
    logic [1:0]              sp_en_i;
    logic                    sp_sext_i;
    logic [WIDTH-1:0]        sp_data_o;
    logic                    pend_set_i;
    logic [COUNTP-1:0]       pend_addr_i;
    logic                    pend_err_o;
    logic                    conflict_o;

    modport master (
        output supervisor, rd_addr_i, wr_addr_i, wr_data_i, wr_en_i, wr_sext_i,
               sp_data_i, sp_en_i, sp_sext_i, pend_set_i, pend_addr_i,
        input  rd_data_o, rd_busy_o, sp_data_o, pend_err_o, conflict_o
    );

    modport slave (
        input  supervisor, rd_addr_i, wr_addr_i, wr_data_i, wr_en_i, wr_sext_i,
               sp_data_i, sp_en_i, sp_sext_i, pend_set_i, pend_addr_i,
        output rd_data_o, rd_busy_o, sp_data_o, pend_err_o, conflict_o
    );

endinterface

// File: rtl/regfile_banked_sb_scoreboard.sv
// Pending-load busy bits per physical register plus sticky double-issue error.
// Latency: set/clear visible one cycle later. Backpressure: none.
module rf_scoreboard #(
    parameter int NPHYS = 17,
    parameter int PW    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_vld_i,
    input  logic [PW-1:0]    set_idx_i,
    input  logic [NPHYS-1:0] clr_i,
    output logic [NPHYS-1:0] busy_o,
    output logic             pend_err_o
);

    logic [NPHYS-1:0] busy_q, busy_d, set_vec;
    logic             err_q, err_d;

    // Set is applied after clear so a back-to-back load keeps the register busy.
    always_comb begin
        set_vec = '0;
        if (set_vld_i) set_vec[set_idx_i] = 1'b1;
        busy_d = (busy_q & ~clr_i) | set_vec;
        err_d  = err_q | (set_vld_i & busy_q[set_idx_i] & ~clr_i[set_idx_i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o     = busy_q;
    assign pend_err_o = err_q;

endmodule

// File: rtl/regfile_banked_sb.sv
// Multi-read register file with banked stack pointer, two write ports and load scoreboard.
// Latency: reads combinational with same-cycle write forwarding; writes land at posedge. Backpressure: none.
module regfile_banked_sb
    import bexkat1_rf_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int SPREG  = 15,
    parameter int NREAD  = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    regfile_banked_sb_if.slave bus
);

    localparam int COUNT = 1 << COUNTP;
    localparam int NPHYS = COUNT + 1;
    localparam int PW    = COUNTP + 1;
    localparam logic [COUNTP-1:0] SP_ARCH = COUNTP'(SPREG);
    localparam logic [PW-1:0]     SSP_IDX = PW'(phys_ssp(COUNTP));

    function automatic logic [PW-1:0] phys(input logic sup, input logic [COUNTP-1:0] a);
        return (sup && a == SP_ARCH) ? SSP_IDX : {1'b0, a};
    endfunction

    logic [WIDTH-1:0] regs_q [NPHYS];
    logic             wr_act, sp_act;
    logic [PW-1:0]    wr_phys, sp_phys, pend_phys;
    logic [WIDTH-1:0] wr_val, sp_val;
    logic [NPHYS-1:0] clr, busy;
    logic             conflict_q, conflict_d;

    assign wr_act    = bus.wr_en_i != 2'b00;
    assign sp_act    = bus.sp_en_i != 2'b00;
    assign wr_phys   = phys(bus.supervisor, bus.wr_addr_i);
    assign sp_phys   = phys(bus.supervisor, SP_ARCH);
    assign pend_phys = phys(bus.supervisor, bus.pend_addr_i);
    assign wr_val    = WIDTH'(extend(size_t'(bus.wr_en_i), bus.wr_sext_i, EXT_W'(bus.wr_data_i)));
    assign sp_val    = WIDTH'(extend(size_t'(bus.sp_en_i), bus.sp_sext_i, EXT_W'(bus.sp_data_i)));
    assign conflict_d = wr_act && sp_act && (wr_phys == sp_phys);

    always_comb begin
        clr = '0;
        if (wr_act) clr[wr_phys] = 1'b1;
        if (sp_act) clr[sp_phys] = 1'b1;
    end

    // SP port is written last so it overrides the general port on a collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (wr_act) regs_q[wr_phys] <= wr_val;
            if (sp_act) regs_q[sp_phys] <= sp_val;
            conflict_q <= conflict_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [PW-1:0] p;
        assign p = phys(bus.supervisor, bus.rd_addr_i[k*COUNTP +: COUNTP]);
        assign bus.rd_data_o[k*WIDTH +: WIDTH] =
            (sp_act && sp_phys == p) ? sp_val :
            (wr_act && wr_phys == p) ? wr_val : regs_q[p];
        assign bus.rd_busy_o[k] = busy[p] & ~clr[p];
    end

    assign bus.sp_data_o = sp_act ? sp_val :
                           (wr_act && wr_phys == sp_phys) ? wr_val : regs_q[sp_phys];
    assign bus.conflict_o = conflict_q;

    rf_scoreboard #(
        .NPHYS (NPHYS),
        .PW    (PW)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_vld_i  (bus.pend_set_i),
        .set_idx_i  (pend_phys),
        .clr_i      (clr),
        .busy_o     (busy),
        .pend_err_o (bus.pend_err_o)
    );

endmodule

// File: tb/tb_regfile_banked_sb.sv
// Randomised and directed check of regfile_banked_sb against a behavioural model.
// Latency: n/a. Backpressure: n/a.
module tb_regfile_banked_sb;

    localparam int WIDTH  = 32;
    localparam int COUNTP = 4;
    localparam int SPREG  = 15;
    localparam int NREAD  = 3;
    localparam int NP     = 17;  // 16 user registers, entry 16 models the ssp

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    regfile_banked_sb_if #(.WIDTH(WIDTH), .COUNTP(COUNTP), .NREAD(NREAD)) rf();

    regfile_banked_sb #(
        .WIDTH(WIDTH), .COUNTP(COUNTP), .SPREG(SPREG), .NREAD(NREAD)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (rf)
    );

    logic [31:0] m_reg  [NP];
    bit          m_busy [NP];
    bit          m_err, m_conf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_err  = 1'b0;
        m_conf = 1'b0;
    endtask

    function automatic int key(input int a);
        return (rf.supervisor && a == SPREG) ? 16 : a;
    endfunction

    function automatic logic [31:0] ext(input logic [1:0] sz, input logic sx, input logic [31:0] d);
        int unsigned v;
        case (sz)
            2'b01: begin v = d % 256;   if (sx && v >= 128)   v = v + 32'hFFFFFF00; end
            2'b10: begin v = d % 65536; if (sx && v >= 32768) v = v + 32'hFFFF0000; end
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic idle();
        rf.wr_addr_i   = '0;
        rf.wr_data_i   = '0;
        rf.wr_en_i     = 2'b00;
        rf.wr_sext_i   = 1'b0;
        rf.sp_data_i   = '0;
        rf.sp_en_i     = 2'b00;
        rf.sp_sext_i   = 1'b0;
        rf.pend_set_i  = 1'b0;
        rf.pend_addr_i = '0;
    endtask

    task automatic rd_all(input logic [3:0] a);
        rf.rd_addr_i = {a, a, a};
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
    task automatic run(input string tag);
        int          wk, sk, pk, t;
        logic [31:0] wv, sv, e;
        bit          wa, sa;
        bit          cl [NP];
        @(negedge clk_i);
        wa = rf.wr_en_i != 2'b00;
        sa = rf.sp_en_i != 2'b00;
        wk = key(int'(rf.wr_addr_i));
        sk = key(SPREG);
        pk = key(int'(rf.pend_addr_i));
        wv = ext(rf.wr_en_i, rf.wr_sext_i, rf.wr_data_i);
        sv = ext(rf.sp_en_i, rf.sp_sext_i, rf.sp_data_i);
        for (int i = 0; i < NP; i++) cl[i] = (wa && wk == i) || (sa && sk == i);
        for (int k = 0; k < NREAD; k++) begin
            t = key(int'(rf.rd_addr_i[k*COUNTP +: COUNTP]));
            e = (sa && sk == t) ? sv : (wa && wk == t) ? wv : m_reg[t];
            chk($sformatf("%s rd%0d_data", tag, k), rf.rd_data_o[k*WIDTH +: WIDTH], e);
            chk($sformatf("%s rd%0d_busy", tag, k), 32'(rf.rd_busy_o[k]), 32'(m_busy[t] && !cl[t]));
        end
        e = sa ? sv : (wa && wk == sk) ? wv : m_reg[sk];
        chk({tag, " sp_data"}, rf.sp_data_o, e);
        m_conf = wa && sa && wk == sk;
        if (rf.pend_set_i && m_busy[pk] && !cl[pk]) m_err = 1'b1;
        if (wa) m_reg[wk] = wv;
        if (sa) m_reg[sk] = sv;
        for (int i = 0; i < NP; i++) if (cl[i]) m_busy[i] = 1'b0;
        if (rf.pend_set_i) m_busy[pk] = 1'b1;
        @(posedge clk_i);
        #1;
        chk({tag, " conflict"}, 32'(rf.conflict_o), 32'(m_conf));
        chk({tag, " pend_err"}, 32'(rf.pend_err_o), 32'(m_err));
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        rf.supervisor = 1'b0;
        rf.rd_addr_i  = {4'd2, 4'd1, 4'd0};
        m_reset();
        #12 rst_i = 1'b0;
        run("reset");

        idle(); rd_all(4'd3);
        rf.wr_addr_i = 4'd3; rf.wr_data_i = 32'h000000F0; rf.wr_en_i = 2'b01; rf.wr_sext_i = 1'b1;
        #1 chk("byte_sext_fwd", rf.rd_data_o[WIDTH-1:0], 32'hFFFFFFF0);
        run("wr_byte");
        idle();
        #1 chk("byte_sext_reg", rf.rd_data_o[WIDTH-1:0], 32'hFFFFFFF0);
        run("r3_hold");

        idle(); rd_all(4'd15);
        rf.sp_data_i = 32'h1000; rf.sp_en_i = 2'b11;
        run("sp_user");
        idle(); rf.supervisor = 1'b1;
        rf.sp_data_i = 32'h2000; rf.sp_en_i = 2'b11;
        run("sp_super");
        idle();
        #1 chk("r15_super", rf.rd_data_o[WIDTH-1:0], 32'h2000);
        rf.supervisor = 1'b0;
        #1 chk("r15_user", rf.rd_data_o[WIDTH-1:0], 32'h1000);
        run("bank_user");

        idle(); rd_all(4'd15);
        rf.wr_addr_i = 4'd15; rf.wr_data_i = 32'hAAAA; rf.wr_en_i = 2'b11;
        rf.sp_data_i = 32'h5555; rf.sp_en_i = 2'b11;
        run("conflict");
        chk("conflict_pulse", 32'(rf.conflict_o), 32'd1);
        idle();
        #1 chk("r15_sp_wins", rf.rd_data_o[WIDTH-1:0], 32'h5555);
        run("conflict_off");
        chk("conflict_drop", 32'(rf.conflict_o), 32'd0);

        idle(); rd_all(4'd5);
        rf.pend_set_i = 1'b1; rf.pend_addr_i = 4'd5;
        run("pend5");
        idle();
        #1 chk("busy5", 32'(rf.rd_busy_o[0]), 32'd1);
        rf.wr_addr_i = 4'd5; rf.wr_data_i = 32'h42; rf.wr_en_i = 2'b11;
        #1 chk("busy5_fwd_clear", 32'(rf.rd_busy_o[0]), 32'd0);
        chk("r5_fwd", rf.rd_data_o[WIDTH-1:0], 32'h42);
        run("wr5");
        idle(); rf.pend_set_i = 1'b1; rf.pend_addr_i = 4'd5;
        run("pend5_a");
        run("pend5_b");
        chk("pend_err_set", 32'(rf.pend_err_o), 32'd1);
        idle();
        run("pend_err_sticky");

        idle(); rd_all(4'd7);
        rf.pend_set_i = 1'b1; rf.pend_addr_i = 4'd7;
        rf.wr_addr_i = 4'd7; rf.wr_data_i = 32'h77; rf.wr_en_i = 2'b11;
        run("set_clr7");
        idle();
        #1 chk("busy7_set_wins", 32'(rf.rd_busy_o[0]), 32'd1);
        run("busy7_hold");
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("async_busy7", 32'(rf.rd_busy_o[0]), 32'd0);
        chk("async_r7", rf.rd_data_o[WIDTH-1:0], 32'h0);
        chk("async_err", 32'(rf.pend_err_o), 32'd0);
        m_reset();
        #4 rst_i = 1'b0;
        run("post_reset");

        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                rst_i = 1'b1;
                m_reset();
                #2 rst_i = 1'b0;
            end
            rf.supervisor  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NREAD; k++)
                rf.rd_addr_i[k*COUNTP +: COUNTP] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            rf.wr_addr_i   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
            rf.wr_data_i   = $urandom;
            rf.wr_en_i     = 2'($urandom);
            rf.wr_sext_i   = 1'($urandom);
            rf.sp_data_i   = $urandom;
            rf.sp_en_i     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            rf.sp_sext_i   = 1'($urandom);
            rf.pend_set_i  = ($urandom_range(0, 3) == 0);
            rf.pend_addr_i = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
            run("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_banked_sb.md
Name: regfile_banked_sb

Overview:
- Multi-read-port register file with a banked stack pointer: user SP lives in regfile[SPREG]; the supervisor SP (ssp) is a separate physical register.
- Two write ports (general write, SP write), each with width-select and optional sign extension, and same-cycle write-through forwarding on every read port.
- A per-physical-register pending-load scoreboard gives the pipeline busy/hazard flags.
- Sits between decode (reads, load issue) and writeback/memory (writes) in the CPU core.

Parameters:
- WIDTH, 32, data width; must be ≥16.
- COUNTP, 4, register address bits; COUNT = 2**COUNTP architectural registers.
- SPREG, 15, architectural index of the stack pointer.
- NREAD, 3, number of read ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- supervisor  in  1  selects the ssp bank for SPREG accesses.
- rd_addr_i  in  NREAD*COUNTP  packed read addresses; port k uses slice k.
- rd_data_o  out  NREAD*WIDTH  packed read data.
- rd_busy_o  out  NREAD  per-port: the read register has a load pending.
- wr_addr_i  in  COUNTP  general write address.
- wr_data_i  in  WIDTH  general write data.
- wr_en_i  in  2  write size: 00 none, 01 byte, 10 half, 11 word.
- wr_sext_i  in  1  sign-extend byte/half writes.
- sp_data_i  in  WIDTH  stack-pointer write data.
- sp_en_i  in  2  SP write size, same encoding as wr_en_i.
- sp_sext_i  in  1  sign-extend SP byte/half writes.
- sp_data_o  out  WIDTH  current SP of the active bank, forwarded.
- pend_set_i  in  1  mark pend_addr_i busy (load issued).
- pend_addr_i  in  COUNTP  target of the issued load.
- pend_err_o  out  1  sticky: pend_set_i hit an already-busy register.
- conflict_o  out  1  registered pulse: both write ports hit the same physical register.

Behaviour:
- Physical map: architectural address a maps to ssp when (supervisor && a==SPREG), otherwise to regfile[a]. The map is evaluated with the current supervisor value for reads, writes and pend_set_i.
- Reset (async): all regfile entries, ssp, busy bits, pend_err_o and conflict_o go to 0. rd_data_o and sp_data_o therefore read 0; rd_busy_o reads 0.
- Extension applied to written data:
  - 01: bits [7:0], zero-extended, or sign-extended when sext=1.
  - 10: bits [15:0], zero- or sign-extended likewise.
  - 11: full word.
  - 00: no write.
- Writes take effect at the posedge.
  - General port writes phys(wr_addr_i) when wr_en_i≠0.
  - SP port writes phys(SPREG) when sp_en_i≠0.
  - Both ports to the same physical register in one cycle: the SP port wins, and conflict_o is 1 for the following cycle only.
- Reads are combinational from registered state, with forwarding.
  - If a write this cycle targets the read's physical register, the extended write value is returned; if both ports target it, the SP port value is returned.
  - sp_data_o follows the same forwarding rules, applied to phys(SPREG).
- Scoreboard: one busy bit per physical register (COUNT+1 bits).
  - pend_set_i sets busy[phys(pend_addr_i)].
  - Any write (either port) to a physical register clears its busy bit.
  - Set and clear of the same register in one cycle: set wins, i.e. the register stays busy (back-to-back loads).
  - pend_set_i to a register that is already busy and not being cleared this cycle sets pend_err_o, which stays set until reset.
- rd_busy_o[k] = busy[phys(rd_addr_i[k])] AND NOT (a write clears that register this cycle). This is the forwarded case; a same-cycle pend_set_i does not raise rd_busy_o until the next cycle.
- A supervisor toggle only changes mapping; no state is modified. A busy user SP remains busy while in supervisor mode and is not visible through the ssp.
- Reset asserted mid-operation discards any pending write and clears all busy bits immediately.

Decomposition:
- Package bexkat1_rf_pkg:
  - typedef size_t (2-bit enum: NONE, BYTE, HALF, WORD).
  - function extend(size_t, sext, data).
  - Constant PHYS_SSP = COUNT, the ssp index in a flat COUNT+1 physical array.
- Sub-module rf_scoreboard: holds the busy bits, the set/clear priority and pend_err_o. Storage, mapping and forwarding stay in the top module.

Test Plan:
- Reset, then read r0..r2 → all rd_data_o=0, rd_busy_o=000, sp_data_o=0.
- User mode: wr r3=0x000000F0 size BYTE with sext=1 → same-cycle read of r3 gives 0xFFFFFFF0; next cycle, registered value is 0xFFFFFFF0.
- Write sp=0x1000 in user mode; set supervisor=1 and write sp=0x2000; read r15 → 0x2000; set supervisor=0 → r15 reads 0x1000.
- Both ports write r15 in user mode in one cycle (wr=0xAAAA, sp=0x5555) → r15=0x5555; conflict_o=1 for exactly one cycle.
- pend_set r5 → rd_busy on r5 is 1 the next cycle; wr r5=0x42 → same cycle rd_busy=0 and data=0x42. pend_set r5 twice with no write between → pend_err_o=1 and stays 1.
- Same cycle: pend_set r7 and write r7 → r7 busy afterwards. Assert rst_i asynchronously while r7 is busy → busy cleared and r7=0 without waiting for a clock edge.
